bubble_buffer_reader: RTL

//  Read-side of the bubble buffer RAM filled by the SPI flash loader. On start, reads 2-bit words

---
 rtl/bubble_pkg.sv | 28 ++
 rtl/bubble_buffer_reader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/bubble_pkg.sv
// Shared bubble-memory definitions: buffer geometry, read lengths, idle pin level and reader states.
package bubble_pkg;

    localparam int unsigned BUF_DEPTH   = 2048;
    localparam int unsigned BUF_WIDTH   = 2;
    localparam int unsigned ADDR_WIDTH  = 11;
    localparam int unsigned COUNT_WIDTH = 11;

    localparam int unsigned PAGE_WORDS  = 512;   // 128 B page, 2 bits per word
    localparam int unsigned BOOT_WORDS  = 1920;  // 480 B bootloader loop

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_RD,
        ST_READY,
        ST_DRAIN,
        ST_DONE
    } bubble_state_t;

    typedef struct packed {
        logic odd;
        logic even;
    } bubble_word_t;

endpackage

// File: rtl/bubble_buffer_reader.sv
// Streams 2-bit words from the bubble buffer RAM onto the odd/even bubble data pins,
// one word per shift strobe, with underrun detection and abort.
module bubble_buffer_reader
    import bubble_pkg::*;
(
    input  logic                  master_clock,
    input  logic                  master_reset_n,
    input  logic                  start,
    input  logic                  read_bootloader,
    input  logic                  abort,
    input  logic                  shift_strobe,
    output logic [ADDR_WIDTH-1:0] buffer_read_address,
    output logic                  buffer_read_enable,
    input  logic [BUF_WIDTH-1:0]  buffer_read_data,
    output logic                  bubble_out_odd,
    output logic                  bubble_out_even,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);

    localparam logic [COUNT_WIDTH-1:0] PAGE_LEN = COUNT_WIDTH'(PAGE_WORDS);
    localparam logic [COUNT_WIDTH-1:0] BOOT_LEN = COUNT_WIDTH'(BOOT_WORDS);

    bubble_state_t          state;
    bubble_word_t           holding;
    logic [COUNT_WIDTH-1:0] word_count;
    logic [COUNT_WIDTH-1:0] word_length;
    logic [COUNT_WIDTH-1:0] next_count_c;

    assign next_count_c = word_count + COUNT_WIDTH'(1);

    // Sequencer: one RAM fetch per word, word held until the strobe that presents it.
    always_ff @(posedge master_clock or negedge master_reset_n) begin
        if (!master_reset_n) begin
            state               <= ST_IDLE;
            holding             <= '0;
            word_count          <= '0;
            word_length         <= '0;
            buffer_read_address <= '0;
            buffer_read_enable  <= 1'b0;
            bubble_out_odd      <= IDLE_LEVEL;
            bubble_out_even     <= IDLE_LEVEL;
            busy                <= 1'b0;
            done                <= 1'b0;
            underrun            <= 1'b0;
        end else begin
            done               <= 1'b0;
            buffer_read_enable <= 1'b0;

            if (abort && (state != ST_IDLE)) begin
                state           <= ST_IDLE;
                busy            <= 1'b0;
                bubble_out_odd  <= IDLE_LEVEL;
                bubble_out_even <= IDLE_LEVEL;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            word_length         <= read_bootloader ? BOOT_LEN : PAGE_LEN;
                            word_count          <= '0;
                            buffer_read_address <= '0;
                            buffer_read_enable  <= 1'b1;
                            underrun            <= 1'b0;
                            busy                <= 1'b1;
                            state               <= ST_FETCH;
                        end
                    end

                    ST_FETCH: begin
                        if (shift_strobe) begin
                            underrun        <= 1'b1;
                            bubble_out_odd  <= IDLE_LEVEL;
                            bubble_out_even <= IDLE_LEVEL;
                        end
                        state <= ST_WAIT_RD;
                    end

                    ST_WAIT_RD: begin
                        holding <= bubble_word_t'(buffer_read_data);
                        if (shift_strobe) begin
                            underrun        <= 1'b1;
                            bubble_out_odd  <= IDLE_LEVEL;
                            bubble_out_even <= IDLE_LEVEL;
                        end
                        state <= ST_READY;
                    end

                    ST_READY: begin
                        if (shift_strobe) begin
                            bubble_out_odd  <= holding.odd;
                            bubble_out_even <= holding.even;
                            word_count      <= next_count_c;
                            if (next_count_c == word_length) begin
                                state <= ST_DRAIN;
                            end else begin
                                buffer_read_address <= buffer_read_address + ADDR_WIDTH'(1);
                                buffer_read_enable  <= 1'b1;
                                state               <= ST_FETCH;
                            end
                        end
                    end

                    // Last word stays on the pins for a full strobe period before going idle.
                    ST_DRAIN: begin
                        if (shift_strobe) begin
                            bubble_out_odd  <= IDLE_LEVEL;
                            bubble_out_even <= IDLE_LEVEL;
                            done            <= 1'b1;
                            state           <= ST_DONE;
                        end
                    end

                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end

                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
